// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared constants and glyph lookup for the 7-segment scan driver.
//   Segment patterns are ordered {g,f,e,d,c,b,a} and are active-low
//   (a 0 bit lights that segment).
//   Contents:
//     SEG_BLANK  - all segments off
//     SEG_DASH   - only segment g lit
//     SEG_TABLE  - 16-entry hex glyph table, entry n = glyph for nibble n
//     seg_glyph  - nibble + mode -> pattern (decimal mode shows dash for 10..15)
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Packed array: the first element listed is the highest index (F).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // mode=1: hex glyphs 0-F. mode=0: decimal, 10..15 render as a dash.
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib, input logic mode);
        if (!mode && (nib > 4'd9))
            return SEG_DASH;
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Combinational nibble -> active-low 7-segment pattern.
//   Ports:
//     nib    in  4  nibble to display
//     mode   in  1  1 = hex glyphs, 0 = decimal (10..15 show dash)
//     blank  in  1  force all segments off
//     glyph  out 7  pattern {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       mode,
    input  logic       blank,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        if (!blank)
            glyph = seg_glyph(nib, mode);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed 7-segment display driver. A frame-stable shadow copy of
//   the DIGITS input nibbles is scanned one digit per SCAN_DIV-cycle slot onto
//   shared active-low anode/segment lines. The first BLANK_CYC cycles of each
//   slot drive all anodes off to avoid ghosting between digits.
//
//   Parameters: DIGITS (>=1), SCAN_DIV (>BLANK_CYC, >=2), BLANK_CYC (>=0)
//   Ports:
//     clk    in   1         system clock, posedge
//     clear  in   1         synchronous active-high reset (overrides all)
//     value  in   4*DIGITS  nibble i = value[4i+3:4i], digit 0 rightmost
//     mode   in   1         1 = hex glyphs, 0 = decimal (10..15 show dash)
//     hold   in   1         1 = keep the current shadow frame
//     dp_in  in   DIGITS    decimal point request per digit, active-high
//     an     out  DIGITS    anode enables, active-low
//     seg    out  7         segments {g,f,e,d,c,b,a}, active-low
//     dp     out  1         decimal point, active-low
//
//   Optional build macro: SEG_LEADING_ZERO_BLANK_EN
//     When defined, digits above the most significant nonzero shadow nibble
//     show no segments (their dp still follows the shadowed dp request).
//     Digit 0 always shows its glyph. Anode timing is unaffected.
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  mode,
    input  logic                  hold,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow;
    logic [DIGITS-1:0]     dp_sh;
    logic                  first;     // set by clear; marks the first free-running cycle

    logic                  tick;
    logic                  last_digit;
    logic                  capture;
    logic                  in_blank;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  lz_blank;
    logic [6:0]            glyph;

    assign tick       = (pre == PW'(SCAN_DIV - 1));
    assign last_digit = (idx == IW'(DIGITS - 1));
    // A new frame is latched at the end of the last digit slot, and once
    // right after clear so the display does not show zeros for a whole frame.
    assign capture    = !hold && (first || (tick && last_digit));
    assign in_blank   = (int'(pre) < BLANK_CYC);

    // Select the current digit's nibble/dp without a variable part-select,
    // so idx never addresses beyond the shadow.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = shadow[4*i +: 4];
                cur_dp  = dp_sh[i];
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank when every nibble at or above the current digit is zero.
    always_comb begin
        lz_blank = (idx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((IW'(i) >= idx) && (shadow[4*i +: 4] != 4'h0))
                lz_blank = 1'b0;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .nib   (cur_nib),
        .mode  (mode),
        .blank (lz_blank),
        .glyph (glyph)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            pre    <= '0;
            idx    <= '0;
            shadow <= '0;
            dp_sh  <= '0;
            first  <= 1'b1;
            an     <= '1;
            seg    <= SEG_BLANK;
            dp     <= 1'b1;
        end else begin
            first <= 1'b0;

            if (tick) begin
                pre <= '0;
                idx <= last_digit ? '0 : idx + IW'(1);
            end else begin
                pre <= pre + PW'(1);
            end

            if (capture) begin
                shadow <= value;
                dp_sh  <= dp_in;
            end

            if (in_blank) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= ~(DIGITS'(1) << idx);
                seg <= glyph;
                dp  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//   Bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
//   A frame-level model (cycle count since clear -> slot position, plus a
//   frame-latched copy of value/dp_in) predicts an/seg/dp for every cycle.
//   Directed literal checks pin the model; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int DG = 4;
    localparam int SD = 4;
    localparam int BC = 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic [15:0]   value = 16'h0;
    logic          mode = 1'b1;
    logic          hold = 1'b0;
    logic [3:0]    dp_in = 4'h0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .clear (clear),
        .value (value),
        .mode  (mode),
        .hold  (hold),
        .dp_in (dp_in),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // ---------------- reference model ----------------
    function automatic logic [6:0] ref_glyph(input int n, input logic m);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        if (!m && n > 9) return 7'h3F;
        return t[n];
    endfunction

    int          m_k;         // cycles since clear released
    logic [15:0] m_sh;
    logic [3:0]  m_dsh;
    bit          m_first;
    bit          started = 0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clk) begin
        int slot_pre, slot_idx, nib;
        bit lz;
        if (clear) begin
            started = 1;
            m_k = 0; m_sh = 16'h0; m_dsh = 4'h0; m_first = 1;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else if (started) begin
            slot_pre = m_k % SD;
            slot_idx = (m_k / SD) % DG;
            nib = int'((m_sh >> (4 * slot_idx)) & 16'hF);
            lz = 0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            lz = (slot_idx > 0) && ((m_sh >> (4 * slot_idx)) == 16'h0);
`endif
            if (slot_pre < BC) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << slot_idx);
                e_seg = lz ? 7'h7F : ref_glyph(nib, mode);
                e_dp  = ~m_dsh[slot_idx];
            end
            // frame boundary = last cycle of the last digit slot
            if (!hold && (m_first || ((m_k + 1) % (DG * SD) == 0))) begin
                m_sh = value; m_dsh = dp_in;
            end
            m_first = 0;
            m_k++;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (started) begin
            n_checks++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
                n_fails++;
                $display("FAIL model_cmp t=%0t an=%h/%h seg=%h/%h dp=%b/%b (got/exp)",
                         $time, an, e_an, seg, e_seg, dp, e_dp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse clear with new inputs; returns at the negedge where digit 0 is lit.
    task automatic restart(input logic [15:0] v, input logic m, input logic [3:0] d);
        clear = 1'b1; value = v; mode = m; dp_in = d; hold = 1'b0;
        wait_n(1);
        clear = 1'b0;
        wait_n(2);
    endtask

    initial begin
        // 1: reset state and first lit slot
        wait_n(3);
        chk("reset_an", {4'h0, an}, 8'h0F);
        chk("reset_seg", {1'b0, seg}, 8'h7F);
        chk("reset_dp", {7'h0, dp}, 8'h01);
        clear = 1'b0; value = 16'h1234; mode = 1'b1;
        wait_n(1);
        chk("first_blank_an", {4'h0, an}, 8'h0F);
        wait_n(1);
        // 2: scan order digit0..3 for 0x1234
        chk("scan_d0_an", {4'h0, an}, 8'h0E); chk("scan_d0_seg", {1'b0, seg}, 8'h19);
        wait_n(3);
        chk("scan_slot_blank", {4'h0, an}, 8'h0F);
        wait_n(1);
        chk("scan_d1_an", {4'h0, an}, 8'h0D); chk("scan_d1_seg", {1'b0, seg}, 8'h30);
        wait_n(4);
        chk("scan_d2_an", {4'h0, an}, 8'h0B); chk("scan_d2_seg", {1'b0, seg}, 8'h24);
        wait_n(4);
        chk("scan_d3_an", {4'h0, an}, 8'h07); chk("scan_d3_seg", {1'b0, seg}, 8'h79);
        wait_n(4);
        chk("scan_repeat_an", {4'h0, an}, 8'h0E); chk("scan_repeat_seg", {1'b0, seg}, 8'h19);

        // 3: decimal mode dash, live mode switch
        restart(16'h00A9, 1'b0, 4'h0);
        chk("dec_d0_seg", {1'b0, seg}, 8'h10);
        wait_n(4);
        chk("dec_d1_dash", {1'b0, seg}, 8'h3F);
        mode = 1'b1;
        wait_n(1);
        chk("hex_d1_A", {1'b0, seg}, 8'h08);

        // 4: tear-free frame update and hold
        restart(16'h1111, 1'b1, 4'h0);
        chk("tear_d0_old", {1'b0, seg}, 8'h79);
        value = 16'h2222;
        wait_n(4); chk("tear_d1_old", {1'b0, seg}, 8'h79);
        wait_n(4); chk("tear_d2_old", {1'b0, seg}, 8'h79);
        wait_n(4); chk("tear_d3_old", {1'b0, seg}, 8'h79);
        wait_n(4); chk("tear_next_frame", {1'b0, seg}, 8'h24);
        hold = 1'b1; value = 16'h3333;
        wait_n(16); chk("hold_keeps", {1'b0, seg}, 8'h24);
        hold = 1'b0;
        wait_n(16); chk("hold_release", {1'b0, seg}, 8'h30);

        // 5: decimal point and clear mid-scan
        restart(16'h0000, 1'b1, 4'b0100);
        chk("dp_d0_off", {7'h0, dp}, 8'h01);
        wait_n(4); chk("dp_d1_off", {7'h0, dp}, 8'h01);
        wait_n(4); chk("dp_d2_on", {7'h0, dp}, 8'h00);
        clear = 1'b1;
        wait_n(1);
        chk("midclear_an", {4'h0, an}, 8'h0F);
        chk("midclear_seg", {1'b0, seg}, 8'h7F);
        clear = 1'b0;
        wait_n(2);
        chk("resume_d0_an", {4'h0, an}, 8'h0E);

        // 6: leading-zero handling
        restart(16'h0050, 1'b1, 4'h0);
        chk("lz_d0", {1'b0, seg}, 8'h40);
        wait_n(4); chk("lz_d1", {1'b0, seg}, 8'h12);
        wait_n(4);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("lz_d2_blank", {1'b0, seg}, 8'h7F);
        wait_n(4); chk("lz_d3_blank", {1'b0, seg}, 8'h7F);
        restart(16'h0000, 1'b1, 4'h0);
        chk("lz_zero_d0", {1'b0, seg}, 8'h40);
        wait_n(4); chk("lz_zero_d1", {1'b0, seg}, 8'h7F);
`else
        chk("lz_d2_shown", {1'b0, seg}, 8'h40);
        wait_n(4); chk("lz_d3_shown", {1'b0, seg}, 8'h40);
`endif

        // randomized phase, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 31) == 0) hold = ~hold;
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) value = {4'h0, 4'h0, 4'($urandom), 4'($urandom)};
            wait_n(1);
        end
        clear = 1'b0;
        wait_n(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
